// File: rtl/stack_bus_master.sv
// -----------------------------------------------------------------------------
// stack_bus_master
//   Host-side initiator for the push/pop stack peripheral. Takes one push or pop
//   command at a time on a valid/ready port and drives the stack's strobes and
//   data bus. It waits for the stack's done flag and returns exactly one
//   response per accepted command: either the popped data or an error code.
//   A local copy of the stack depth is kept so that overflow and underflow
//   are refused without touching the bus.
//
// Parameters
//   DATA_W   data bus width
//   DEPTH    stack capacity in entries (must fit in the 5-bit depth port)
//   TIMEOUT  WAIT cycles allowed before a command aborts with a timeout (>=2)
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; ready only while idle
//   cmd_op, cmd_data      0=push / 1=pop, push payload
//   rsp_valid             one-cycle response strobe
//   rsp_data, rsp_err     popped data (0 otherwise), 00 ok/01 ovf/10 unf/11 tmo
//   stk_push, stk_pop     one-cycle strobes to the stack
//   stk_dout, stk_doe     bus data and drive enable (push only)
//   stk_din               bus data returned by the stack
//   stk_done/empty/full   stack status
//   depth                 local entry count, 0..DEPTH
// -----------------------------------------------------------------------------
module stack_bus_master #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_err,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [DATA_W-1:0] stk_dout,
  output logic              stk_doe,
  input  logic [DATA_W-1:0] stk_din,
  input  logic              stk_done,
  input  logic              stk_empty,
  input  logic              stk_full,
  output logic [4:0]        depth
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_RESP
  } state_t;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_OVF = 2'b01;
  localparam logic [1:0] ERR_UNF = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;

  localparam int         TW        = $clog2(TIMEOUT + 1);
  localparam logic [4:0] DEPTH_MAX = 5'(DEPTH);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                op_q, op_d;
  logic [1:0]          pend_err_q, pend_err_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [4:0]          depth_q, depth_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [1:0]          rsp_err_q, rsp_err_d;
  logic                stk_push_q, stk_push_d;
  logic                stk_pop_q, stk_pop_d;
  logic [DATA_W-1:0]   stk_dout_q, stk_dout_d;
  logic                stk_doe_q, stk_doe_d;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    pend_err_d  = pend_err_q;
    timer_d     = timer_q;
    depth_d     = depth_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    stk_dout_d  = stk_dout_q;
    stk_doe_d   = stk_doe_q;
    stk_push_d  = 1'b0;
    stk_pop_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d       = cmd_op;
          pend_err_d = ERR_OK;
          state_d    = S_ISSUE;
          // The refusal decision is made at acceptance so the strobes can be
          // registered into the ISSUE cycle. A refused command still passes
          // through ISSUE, with the bus left idle, before it responds.
          if (!cmd_op) begin
            if (depth_q == DEPTH_MAX || stk_full) begin
              pend_err_d = ERR_OVF;
            end else begin
              stk_push_d = 1'b1;
              stk_doe_d  = 1'b1;
              stk_dout_d = cmd_data;
            end
          end else begin
            stk_doe_d = 1'b0;
            if (depth_q == 5'd0 || stk_empty) begin
              pend_err_d = ERR_UNF;
            end else begin
              stk_pop_d = 1'b1;
            end
          end
        end
      end

      S_ISSUE: begin
        timer_d = '0;
        if (pend_err_q != ERR_OK) begin
          rsp_err_d  = pend_err_q;
          rsp_data_d = '0;
          state_d    = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        // Done is not trusted in the first WAIT cycle: the stack may still be
        // showing completion of the previous instruction.
        if (timer_q != '0 && stk_done) begin
          if (!op_q) begin
            rsp_err_d  = ERR_OK;
            rsp_data_d = '0;
            if (depth_q != DEPTH_MAX) depth_d = depth_q + 5'd1;
            state_d = S_RESP;
          end else begin
            state_d = S_CAPTURE;
          end
        end else if (timer_q == TIMER_LAST) begin
          rsp_err_d  = ERR_TMO;
          rsp_data_d = '0;
          state_d    = S_RESP;
        end
      end

      S_CAPTURE: begin
        rsp_data_d = stk_din;
        rsp_err_d  = ERR_OK;
        if (depth_q != 5'd0) depth_d = depth_q - 5'd1;
        state_d = S_RESP;
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs below are registered views of the state being entered.
    if (state_d == S_RESP) stk_doe_d = 1'b0;
    cmd_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP) && (state_q != S_RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= 1'b0;
      pend_err_q  <= ERR_OK;
      timer_q     <= '0;
      depth_q     <= 5'd0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= ERR_OK;
      stk_push_q  <= 1'b0;
      stk_pop_q   <= 1'b0;
      stk_dout_q  <= '0;
      stk_doe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      pend_err_q  <= pend_err_d;
      timer_q     <= timer_d;
      depth_q     <= depth_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      stk_push_q  <= stk_push_d;
      stk_pop_q   <= stk_pop_d;
      stk_dout_q  <= stk_dout_d;
      stk_doe_q   <= stk_doe_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign stk_push  = stk_push_q;
  assign stk_pop   = stk_pop_q;
  assign stk_dout  = stk_dout_q;
  assign stk_doe   = stk_doe_q;
  assign depth     = depth_q;

endmodule

// File: tb/tb_stack_bus_master.sv
module tb_stack_bus_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_op = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic [1:0] rsp_err;
  logic       stk_push;
  logic       stk_pop;
  logic [7:0] stk_dout;
  logic       stk_doe;
  logic [7:0] stk_din;
  logic       stk_done;
  logic       stk_empty;
  logic       stk_full;
  logic [4:0] depth;

  stack_bus_master #(.DATA_W(8), .DEPTH(16), .TIMEOUT(15)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .stk_push  (stk_push),
    .stk_pop   (stk_pop),
    .stk_dout  (stk_dout),
    .stk_doe   (stk_doe),
    .stk_din   (stk_din),
    .stk_done  (stk_done),
    .stk_empty (stk_empty),
    .stk_full  (stk_full),
    .depth     (depth)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural stack peripheral
  logic [7:0] mem [16];
  int         sp = 0;
  logic [7:0] din_r = 8'h00;
  logic       done_en = 1'b1;

  always @(posedge clk) begin
    if (!rst_n) begin
      sp <= 0;
    end else if (stk_push && sp < 16) begin
      mem[sp] <= stk_dout;
      sp      <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      din_r <= mem[sp-1];
      sp    <= sp - 1;
    end
  end

  assign stk_din   = din_r;
  assign stk_done  = done_en;
  assign stk_empty = (sp == 0);
  assign stk_full  = (sp == 16);

  // Scoreboard
  typedef struct {
    logic [7:0] data;
    logic [1:0] err;
    int         dep;
    int         acc;
    int         lat;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         push_pulses = 0;
  int         pop_pulses = 0;
  logic [7:0] bus_data = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: bus rules every cycle, responses against the queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (stk_push && stk_pop) chk("push_and_pop_together", 1, 0);
        if (stk_push) push_pulses++;
        if (stk_pop) begin
          pop_pulses++;
          chk("pop_doe", stk_doe, 0);
        end
        if (stk_doe) chk("bus_dout", stk_dout, bus_data);
        if (rsp_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_rsp", rsp_valid, 0);
          end else begin
            e = q.pop_front();
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_err", rsp_err, e.err);
            chk("rsp_depth", depth, e.dep);
            chk("rsp_latency", cyc - e.acc, e.lat);
            chk("rsp_doe", stk_doe, 0);
          end
        end
      end
    end
  end

  task automatic send(input logic op, input logic [7:0] d, input logic [7:0] ed,
                      input logic [1:0] ee, input int edep, input int lat, input bit want);
    exp_t e;
    int   n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      chk("cmd_ready_timeout", cmd_ready, 1);
    end else begin
      if (!op) bus_data = d;
      if (want) begin
        e.data = ed; e.err = ee; e.dep = edep; e.acc = cyc; e.lat = lat;
        q.push_back(e);
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      chk("rsp_timeout_pending", q.size(), 0);
      q.delete();
    end
  endtask

  initial begin
    int p0;
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_stk_push", stk_push, 0);
    chk("rst_stk_pop", stk_pop, 0);
    chk("rst_stk_doe", stk_doe, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_stk_dout", stk_dout, 0);
    chk("rst_depth", depth, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1);

    // Push then pop 0xA5
    p0 = push_pulses;
    send(1'b0, 8'hA5, 8'h00, 2'b00, 1, 4, 1'b1);
    drain();
    chk("push_a5_pulses", push_pulses, p0 + 1);
    p0 = pop_pulses;
    send(1'b1, 8'h00, 8'hA5, 2'b00, 0, 5, 1'b1);
    drain();
    chk("pop_a5_pulses", pop_pulses, p0 + 1);

    // Underflow refusal
    p0 = pop_pulses;
    send(1'b1, 8'h00, 8'h00, 2'b10, 0, 2, 1'b1);
    drain();
    chk("underflow_no_pop", pop_pulses, p0);

    // Fill to capacity, then overflow refusal
    for (int i = 0; i < 16; i++) begin
      send(1'b0, 8'h10 + 8'(i), 8'h00, 2'b00, i + 1, 4, 1'b1);
      drain();
    end
    p0 = push_pulses;
    send(1'b0, 8'hEE, 8'h00, 2'b01, 16, 2, 1'b1);
    drain();
    chk("overflow_no_push", push_pulses, p0);

    // LIFO order from the full stack
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 8'h00, 8'h1F - 8'(i), 2'b00, 15 - i, 5, 1'b1);
      drain();
    end

    // Push timeout with done held low
    done_en = 1'b0;
    send(1'b0, 8'h3C, 8'h00, 2'b11, 13, 17, 1'b1);
    drain();
    done_en = 1'b1;

    // Reset in the WAIT phase of a pop
    done_en = 1'b0;
    send(1'b1, 8'h00, 8'h00, 2'b00, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_depth", depth, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_doe", stk_doe, 0);
    rst_n   = 1'b1;
    done_en = 1'b1;
    @(negedge clk);
    chk("midrst_ready", cmd_ready, 1);
    repeat (20) @(negedge clk);
    chk("midrst_idle_depth", depth, 0);

    // Recovery
    send(1'b0, 8'h5A, 8'h00, 2'b00, 1, 4, 1'b1);
    drain();
    send(1'b1, 8'h00, 8'h5A, 2'b00, 0, 5, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
